rf_wb_scheduler: RTL and testbench

//  Schedules the single register-file write port between the in-order pipeline

---
 rtl/rf_wb_scheduler.sv | 122 ++++++++++++
 tb/tb_rf_wb_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single register-file write port between pipeline writeback and MDU results,
// and tracks outstanding MDU destinations to generate the issue stall.
module rf_wb_scheduler #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_OUT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wvalid,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        mdu_wvalid,
    output logic        mdu_wready,
    input  logic [4:0]  mdu_waddr,
    input  logic [31:0] mdu_wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rsc,
    input  logic [4:0]  iss_rtc,
    input  logic [4:0]  iss_rdc,
    input  logic        iss_long,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_wc,
    output logic [31:0] rf_wdata,
    output logic        err_waw
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C   = FIFO_DEPTH[PW:0];
    localparam logic [4:0]  MAX_OUT_C = MAX_OUT[4:0];

    logic [4:0]    fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [31:0]   pending, pending_nxt;
    logic [4:0]    outstanding;
    logic          full, push, pop, pipe_win, set_en, dec_en;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign full       = (count == DEPTH_C);
    assign mdu_wready = !full;
    assign push       = mdu_wvalid & !full;
    assign pipe_win   = pipe_wvalid & (pipe_waddr != 5'd0);
    assign pop        = !pipe_win & (count != '0);
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // Stall looks only at registered pending state, so a bit clearing this cycle still stalls.
    assign stall  = iss_valid & (pending[iss_rsc] | pending[iss_rtc] | pending[iss_rdc]
                    | (iss_long & (outstanding == MAX_OUT_C)));
    assign set_en = iss_valid & iss_long & !stall & (iss_rdc != 5'd0);
    assign dec_en = pop & pending[head_addr];

    always_comb begin
        pending_nxt = pending;
        if (set_en)
            pending_nxt[iss_rdc] = 1'b1;
        if (pop)
            pending_nxt[head_addr] = 1'b0;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mdu_waddr;
            fifo_data[wr_ptr] <= mdu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pending     <= '0;
            outstanding <= '0;
            err_waw     <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            pending <= pending_nxt;
            case ({set_en, dec_en})
                2'b10:   outstanding <= outstanding + 5'd1;
                2'b01:   outstanding <= outstanding - 5'd1;
                default: outstanding <= outstanding;
            endcase
            if (pipe_win & pending[pipe_waddr])
                err_waw <= 1'b1;
        end
    end

    // Pipeline wins; an r0 pipeline write only reaches the port when nothing is buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_wc    <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (pipe_win) begin
            rf_we    <= 1'b1;
            rf_wc    <= pipe_waddr;
            rf_wdata <= pipe_wdata;
        end else if (pop) begin
            rf_we    <= 1'b1;
            rf_wc    <= head_addr;
            rf_wdata <= head_data;
        end else if (pipe_wvalid) begin
            rf_we    <= 1'b1;
            rf_wc    <= 5'd0;
            rf_wdata <= pipe_wdata;
        end else begin
            rf_we    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: vector table plus hand-written multi-cycle sequences.
module tb_rf_wb_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wvalid = 1'b0;
    logic [4:0]  pipe_waddr = '0;
    logic [31:0] pipe_wdata = '0;
    logic        mdu_wvalid = 1'b0;
    logic        mdu_wready;
    logic [4:0]  mdu_waddr = '0;
    logic [31:0] mdu_wdata = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rsc = '0, iss_rtc = '0, iss_rdc = '0;
    logic        iss_long = 1'b0;
    logic        stall, rf_we, err_waw;
    logic [4:0]  rf_wc;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] regs [32];

    rf_wb_scheduler #(.FIFO_DEPTH(2), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_wvalid(pipe_wvalid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mdu_wvalid(mdu_wvalid), .mdu_wready(mdu_wready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .iss_valid(iss_valid), .iss_rsc(iss_rsc), .iss_rtc(iss_rtc), .iss_rdc(iss_rdc), .iss_long(iss_long),
        .stall(stall), .rf_we(rf_we), .rf_wc(rf_wc), .rf_wdata(rf_wdata), .err_waw(err_waw)
    );

    always #5 clk = ~clk;

    // Register-file model: captures the write port on the negedge.
    always @(negedge clk)
        if (rf_we && rf_wc != 5'd0)
            regs[rf_wc] <= rf_wdata;

    typedef struct {
        logic pv; logic [4:0] pa; logic [31:0] pd;
        logic mv; logic [4:0] ma; logic [31:0] md;
        logic iv; logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic il;
        logic e_we; logic [4:0] e_wc; logic [31:0] e_wd;
        logic e_rdy; logic e_stall; logic e_err;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        pipe_wvalid = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        mdu_wvalid = 1'b0; mdu_waddr = '0; mdu_wdata = '0;
        iss_valid = 1'b0; iss_rsc = '0; iss_rtc = '0; iss_rdc = '0; iss_long = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int mi;
    logic [31:0] exp_rdy [10];

    initial begin
        //           pv pa     pd            mv ma     md             iv rs     rt     rd     il   we wc     wd            rdy stall err
        vt[0]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       0, 5'd0, 5'd0, 5'd0, 0,   0, 5'd0, 32'h0,       1, 0, 0};
        vt[1]  = '{1, 5'd7, 32'h1234,    0, 5'd0,  32'h0,       0, 5'd0, 5'd0, 5'd0, 0,   0, 5'd0, 32'h0,       1, 0, 0};
        vt[2]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 5'd0, 5'd0, 5'd9, 1,   1, 5'd7, 32'h1234,    1, 0, 0};
        vt[3]  = '{1, 5'd8, 32'h5,       1, 5'd9,  32'hBEEF,    1, 5'd9, 5'd0, 5'd0, 0,   0, 5'd0, 32'h0,       1, 1, 0};
        vt[4]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 5'd9, 5'd0, 5'd0, 0,   1, 5'd8, 32'h5,       1, 1, 0};
        vt[5]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 5'd9, 5'd0, 5'd0, 0,   1, 5'd9, 32'hBEEF,    1, 0, 0};
        vt[6]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 5'd0, 5'd0, 5'd3, 1,   0, 5'd0, 32'h0,       1, 0, 0};
        vt[7]  = '{1, 5'd3, 32'hAA,      0, 5'd0,  32'h0,       0, 5'd0, 5'd0, 5'd0, 0,   0, 5'd0, 32'h0,       1, 0, 0};
        vt[8]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       0, 5'd0, 5'd0, 5'd0, 0,   1, 5'd3, 32'hAA,      1, 0, 1};
        vt[9]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 5'd0, 5'd3, 5'd0, 0,   0, 5'd0, 32'h0,       1, 1, 1};
        vt[10] = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 5'd0, 5'd0, 5'd3, 0,   0, 5'd0, 32'h0,       1, 1, 1};
        vt[11] = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 5'd4, 5'd5, 5'd6, 0,   0, 5'd0, 32'h0,       1, 0, 1};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            pipe_wvalid = vt[i].pv; pipe_waddr = vt[i].pa; pipe_wdata = vt[i].pd;
            mdu_wvalid = vt[i].mv; mdu_waddr = vt[i].ma; mdu_wdata = vt[i].md;
            iss_valid = vt[i].iv; iss_rsc = vt[i].rs; iss_rtc = vt[i].rt;
            iss_rdc = vt[i].rd; iss_long = vt[i].il;
            @(negedge clk);
            chk($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vt[i].e_we));
            if (vt[i].e_we) begin
                chk($sformatf("vec%0d rf_wc", i), 32'(rf_wc), 32'(vt[i].e_wc));
                chk($sformatf("vec%0d rf_wdata", i), rf_wdata, vt[i].e_wd);
            end
            chk($sformatf("vec%0d mdu_wready", i), 32'(mdu_wready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d err_waw", i), 32'(err_waw), 32'(vt[i].e_err));
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("regfile r7", regs[7], 32'h1234);
        chk("regfile r8", regs[8], 32'h5);
        chk("regfile r9", regs[9], 32'hBEEF);

        // Back-pressure: pipe busy 6 cycles while the MDU offers 3 results.
        do_reset();
        exp_rdy = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        mi = 0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            pipe_wvalid = (c < 6);
            pipe_waddr  = 5'(c + 1);
            pipe_wdata  = 32'h100 + 32'(c);
            mdu_wvalid  = (mi < 3);
            mdu_waddr   = 5'(11 + mi);
            mdu_wdata   = 32'hA00 + 32'(mi);
            @(negedge clk);
            chk($sformatf("bp c%0d mdu_wready", c), 32'(mdu_wready), exp_rdy[c]);
            if (mdu_wvalid && mdu_wready) begin
                if (mi == 2)
                    chk("bp third accept cycle", 32'(c), 32'd7);
                mi++;
            end
        end
        chk("bp accepted count", 32'(mi), 32'd3);
        next_cycle();
        idle_inputs();
        repeat (2) next_cycle();
        for (int r = 1; r <= 6; r++)
            chk($sformatf("bp pipe r%0d", r), regs[r], 32'h100 + 32'(r - 1));
        for (int r = 0; r < 3; r++)
            chk($sformatf("bp mdu r%0d", 11 + r), regs[11 + r], 32'hA00 + 32'(r));

        // Outstanding limit, release by an MDU write, sticky err_waw.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            iss_valid = 1'b1; iss_long = 1'b1; iss_rdc = 5'(k); iss_rsc = '0; iss_rtc = '0;
            @(negedge clk);
            chk($sformatf("max long issue %0d stall", k), 32'(stall), 32'd0);
        end
        next_cycle();
        iss_rdc = 5'd5;
        @(negedge clk);
        chk("max 5th long stall", 32'(stall), 32'd1);
        next_cycle();
        iss_long = 1'b0; iss_rsc = 5'd20; iss_rdc = 5'd21;
        @(negedge clk);
        chk("max short issue stall", 32'(stall), 32'd0);
        next_cycle();
        idle_inputs();
        pipe_wvalid = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h7;
        @(negedge clk);
        chk("waw before", 32'(err_waw), 32'd0);
        next_cycle();
        idle_inputs();
        mdu_wvalid = 1'b1; mdu_waddr = 5'd1; mdu_wdata = 32'h77;
        @(negedge clk);
        chk("waw set", 32'(err_waw), 32'd1);
        next_cycle();
        idle_inputs();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rdc = 5'd5;
        @(negedge clk);
        chk("max clearing cycle still stalls", 32'(stall), 32'd1);
        chk("waw held 1", 32'(err_waw), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("max after clear stall", 32'(stall), 32'd0);
        chk("waw held 2", 32'(err_waw), 32'd1);
        chk("mdu r1 written", 32'(rf_we && rf_wc == 5'd1 && rf_wdata == 32'h77), 32'd1);
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("waw cleared by rst", 32'(err_waw), 32'd0);
        #1 rst = 1'b0;

        // Reset with two buffered MDU results and a pending register.
        do_reset();
        next_cycle();
        pipe_wvalid = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h11;
        mdu_wvalid = 1'b1; mdu_waddr = 5'd14; mdu_wdata = 32'hE;
        iss_valid = 1'b1; iss_long = 1'b1; iss_rdc = 5'd14;
        next_cycle();
        iss_valid = 1'b0; iss_long = 1'b0; iss_rdc = '0;
        pipe_waddr = 5'd2; mdu_waddr = 5'd15;
        next_cycle();
        mdu_wvalid = 1'b0;
        @(negedge clk);
        chk("rst pre full", 32'(mdu_wready), 32'd0);
        #2 rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst rf_we", 32'(rf_we), 32'd0);
        chk("rst rf_wc", 32'(rf_wc), 32'd0);
        chk("rst rf_wdata", rf_wdata, 32'd0);
        chk("rst mdu_wready", 32'(mdu_wready), 32'd1);
        iss_valid = 1'b1;
        for (int r = 0; r < 32; r++) begin
            iss_rsc = 5'(r);
            #1;
            chk($sformatf("rst pending r%0d", r), 32'(stall), 32'd0);
        end
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("rst discard c%0d", c), 32'(rf_we), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
